// File: rtl/tmds_rx_channel_if.sv
// Bus between one TMDS receive channel and its consumer: DDR capture pair in, decoded symbols out.
// With TMDS_RX_STATS_EN defined the bus also carries lock_losses and slip_pos.
interface tmds_rx_channel_if;
  logic [1:0] rx_bits;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       de;
  logic       valid;
  logic       locked;
`ifdef TMDS_RX_STATS_EN
  logic [15:0] lock_losses;
  logic [3:0]  slip_pos;

  modport master (input rx_bits, output data, ctl, de, valid, locked, lock_losses, slip_pos);
  modport slave  (output rx_bits, input data, ctl, de, valid, locked, lock_losses, slip_pos);
`else
  modport master (input rx_bits, output data, ctl, de, valid, locked);
  modport slave  (output rx_bits, input data, ctl, de, valid, locked);
`endif
endinterface

// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: word alignment by bit slipping on control tokens, then symbol decode.
// Optional statistics outputs (lock_losses, slip_pos) are enabled with TMDS_RX_STATS_EN.
module tmds_rx_channel #(
  parameter int SEARCH_WORDS = 16,
  parameter int CTL_RUN      = 8,
  parameter int LOSS_WORDS   = 2048
) (
  input  logic              clk_x5,
  input  logic              reset,
  tmds_rx_channel_if.master bus
);

  localparam int WC_W = $clog2(SEARCH_WORDS + 1);
  localparam int RC_W = $clog2(CTL_RUN + 1);
  localparam int LC_W = $clog2(LOSS_WORDS + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  logic [10:0]     hist_q;
  logic [2:0]      phase_q;
  logic [3:0]      slip_q;
  logic            capture_q;
  logic [9:0]      sym_q;
  logic            symValid_q;
  state_t          state_q;
  logic [WC_W-1:0] wc_q;
  logic [RC_W-1:0] rc_q;
  logic [LC_W-1:0] lc_q;
  logic [7:0]      data_q;
  logic [1:0]      ctl_q;
  logic            de_q;
  logic            valid_q;
  logic            locked_q;
`ifdef TMDS_RX_STATS_EN
  logic [15:0]     lockLosses_q;
`endif

  logic [2:0]      endPhase_d;
  logic            isCtl_d;
  logic [1:0]      ctlDec_d;
  logic [7:0]      plain_d;
  logic [7:0]      dataDec_d;

  // Cycle within the 5-cycle word in which the last bit of the slipped word arrives.
  always_comb begin
    endPhase_d = 3'd4;
    case (slip_q)
      4'd1, 4'd2: endPhase_d = 3'd0;
      4'd3, 4'd4: endPhase_d = 3'd1;
      4'd5, 4'd6: endPhase_d = 3'd2;
      4'd7, 4'd8: endPhase_d = 3'd3;
      default:    endPhase_d = 3'd4;
    endcase
  end

  always_comb begin
    isCtl_d  = 1'b1;
    ctlDec_d = 2'b00;
    case (sym_q)
      10'b1101010100: ctlDec_d = 2'b00;
      10'b0010101011: ctlDec_d = 2'b01;
      10'b0101010100: ctlDec_d = 2'b10;
      10'b1010101011: ctlDec_d = 2'b11;
      default:        isCtl_d  = 1'b0;
    endcase
    plain_d   = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dataDec_d = {plain_d[7:1] ^ plain_d[6:0] ^ {7{~sym_q[8]}}, plain_d[0]};
  end

  // Newest pair lands in hist_q[10:9]; an even slip ends its word on the later bit of a pair.
  always_ff @(posedge clk_x5 or posedge reset) begin
    if (reset) begin
      hist_q     <= '0;
      phase_q    <= '0;
      capture_q  <= 1'b0;
      sym_q      <= '0;
      symValid_q <= 1'b0;
    end else begin
      hist_q     <= {bus.rx_bits[1], bus.rx_bits[0], hist_q[10:2]};
      phase_q    <= (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      capture_q  <= (phase_q == endPhase_d);
      symValid_q <= capture_q;
      if (capture_q) begin
        sym_q <= slip_q[0] ? hist_q[9:0] : hist_q[10:1];
      end
    end
  end

  always_ff @(posedge clk_x5 or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      slip_q       <= '0;
      wc_q         <= '0;
      rc_q         <= '0;
      lc_q         <= '0;
      data_q       <= '0;
      ctl_q        <= '0;
      de_q         <= 1'b0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
`ifdef TMDS_RX_STATS_EN
      lockLosses_q <= '0;
`endif
    end else begin
      valid_q <= symValid_q;
      if (symValid_q) begin
        de_q <= ~isCtl_d;
        if (isCtl_d) begin
          ctl_q <= ctlDec_d;
        end else begin
          data_q <= dataDec_d;
        end
        case (state_q)
          SEARCH: begin
            if (isCtl_d && rc_q == RC_W'(CTL_RUN - 1)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              wc_q     <= '0;
              rc_q     <= '0;
              lc_q     <= '0;
            end else if (wc_q == WC_W'(SEARCH_WORDS - 1)) begin
              slip_q <= (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
              wc_q   <= '0;
              rc_q   <= '0;
            end else begin
              wc_q <= wc_q + 1'b1;
              rc_q <= isCtl_d ? rc_q + 1'b1 : '0;
            end
          end
          LOCKED: begin
            if (isCtl_d) begin
              lc_q <= '0;
            end else if (lc_q == LC_W'(LOSS_WORDS - 1)) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              wc_q     <= '0;
              rc_q     <= '0;
              lc_q     <= '0;
`ifdef TMDS_RX_STATS_EN
              if (lockLosses_q != 16'hFFFF) begin
                lockLosses_q <= lockLosses_q + 16'd1;
              end
`endif
            end else begin
              lc_q <= lc_q + 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus.data   = data_q;
  assign bus.ctl    = ctl_q;
  assign bus.de     = de_q;
  assign bus.valid  = valid_q;
  assign bus.locked = locked_q;
`ifdef TMDS_RX_STATS_EN
  assign bus.lock_losses = lockLosses_q;
  assign bus.slip_pos    = slip_q;
`endif

endmodule
